// File: rtl/sideways_mem_ctrl.sv
// sideways_mem_ctrl
// Shares one synchronous single-port memory between video fetch and the 6502.
// Decodes main RAM, the OS ROM and the paged sideways banks, and holds the
// ROMSEL bank latch together with per-bank populated / writable masks.
//
// Physical store layout: MEM_ADDR = {slot, offset[13:0]}
//   slot 0,1      : main RAM (&0000-&7FFF, slot = A14)
//   slot 2        : OS ROM   (&C000-&FBFF, &FF00-&FFFF)
//   slot bank+3   : sideways bank (&8000-&BFFF)
//
// Slot protocol: a slot starts on a RAM_en pulse. RAM_en & PROC_en selects a
// video slot, RAM_en alone a CPU slot. The access strobe is registered
// (cycle t), memory returns data in t+1, and the data is captured into
// vDATA or pDATA_OUT at the end of t+1 by a two-stage slot tag. Pulses of
// RAM_en are at least 4 CLK apart, so at most one slot is in flight.
module sideways_mem_ctrl #(
  parameter int          BANK_BITS    = 4,
  parameter logic [15:0] BANK_PRESENT = 16'h0003,
  parameter logic [15:0] SWRAM_MASK   = 16'h0000,
  parameter int          MEM_AW       = BANK_BITS + 15
) (
  input  logic                 CLK,
  input  logic                 nRESET,
  input  logic                 RAM_en,
  input  logic                 PROC_en,
  input  logic [15:0]          pADDR,
  input  logic                 RnW,
  input  logic [7:0]           pDATA_IN,
  input  logic                 nROMSEL,
  output logic [7:0]           pDATA_OUT,
  output logic                 pDATA_OE,
  input  logic [14:0]          vADDR,
  output logic [7:0]           vDATA,
  output logic [BANK_BITS-1:0] ROM_BANK,
  output logic [MEM_AW-1:0]    MEM_ADDR,
  output logic                 MEM_EN,
  output logic                 MEM_WE,
  output logic [7:0]           MEM_WDATA,
  input  logic [7:0]           MEM_RDATA
);

  localparam int SLOT_W    = BANK_BITS + 1;
  localparam int PHYS_W    = SLOT_W + 14;
  localparam int NUM_BANKS = 2 ** BANK_BITS;

  // What the data returning from memory two cycles later belongs to.
  typedef enum logic [1:0] {
    TAG_NONE   = 2'd0,
    TAG_VIDEO  = 2'd1,
    TAG_CPU    = 2'd2,
    TAG_CPU_FF = 2'd3
  } tag_e;

  // Only the masks for banks that can actually be selected matter.
  localparam logic [NUM_BANKS-1:0] PRESENT_BITS = BANK_PRESENT[NUM_BANKS-1:0];
  localparam logic [NUM_BANKS-1:0] WRITE_BITS   = SWRAM_MASK[NUM_BANKS-1:0];

  // Registered state
  logic [7:0]           p_data_out_q, p_data_out_d;
  logic [7:0]           v_data_q,     v_data_d;
  logic [BANK_BITS-1:0] rom_bank_q,   rom_bank_d;
  logic [MEM_AW-1:0]    mem_addr_q,   mem_addr_d;
  logic                 mem_en_q,     mem_en_d;
  logic                 mem_we_q,     mem_we_d;
  logic [7:0]           mem_wdata_q,  mem_wdata_d;
  tag_e                 tag0_q,       tag0_d;
  tag_e                 tag1_q,       tag1_d;

  // Region decode of the processor address
  logic is_ram;
  logic is_bank;
  logic is_io;
  logic is_os;

  assign is_ram  = ~pADDR[15];
  assign is_bank = (pADDR[15:14] == 2'b10);
  assign is_io   = (pADDR[15:10] == 6'b111111) && (pADDR[9:8] != 2'b11);
  assign is_os   = (pADDR[15:14] == 2'b11) && ~is_io;

  // Bus drive is purely a function of the current processor cycle.
  assign pDATA_OE = RnW & ~is_io;

  // Mask lookups for the currently selected bank
  logic bank_present;
  logic bank_writable;

  assign bank_present  = PRESENT_BITS[rom_bank_q];
  assign bank_writable = WRITE_BITS[rom_bank_q];

  // Physical address of the processor access
  logic [SLOT_W-1:0] cpu_slot;
  logic [PHYS_W-1:0] cpu_phys;
  logic [MEM_AW-1:0] cpu_addr;
  logic [MEM_AW-1:0] vid_addr;

  // Map the processor region onto a store slot.
  always_comb begin
    cpu_slot = '0;
    if (is_ram) begin
      cpu_slot = {{(SLOT_W-1){1'b0}}, pADDR[14]};
    end else if (is_bank) begin
      cpu_slot = SLOT_W'(rom_bank_q) + SLOT_W'(3);
    end else begin
      cpu_slot = SLOT_W'(2);
    end
  end

  assign cpu_phys = {cpu_slot, pADDR[13:0]};
  assign cpu_addr = MEM_AW'(cpu_phys);
  assign vid_addr = MEM_AW'(vADDR);

  // Slot sequencer, ROMSEL latch and read-data capture.
  always_comb begin
    p_data_out_d = p_data_out_q;
    v_data_d     = v_data_q;
    rom_bank_d   = rom_bank_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    tag0_d       = TAG_NONE;
    tag1_d       = tag0_q;

    if (RAM_en && PROC_en) begin
      // Video slot: always a main-RAM read.
      mem_addr_d = vid_addr;
      mem_en_d   = 1'b1;
      tag0_d     = TAG_VIDEO;
    end else if (RAM_en) begin
      if (RnW) begin
        if (is_ram || is_os || (is_bank && bank_present)) begin
          mem_addr_d = cpu_addr;
          mem_en_d   = 1'b1;
          tag0_d     = TAG_CPU;
        end else if (is_bank) begin
          // Empty socket: no access, the bus floats high.
          tag0_d = TAG_CPU_FF;
        end
        // IO reads make no access and leave pDATA_OUT alone.
      end else begin
        if (is_ram || (is_bank && bank_writable)) begin
          mem_addr_d  = cpu_addr;
          mem_en_d    = 1'b1;
          mem_we_d    = 1'b1;
          mem_wdata_d = pDATA_IN;
        end
        // ROM, OS and IO writes are dropped.
      end
    end

    // The ROMSEL strobe lands in a video slot, so the next CPU slot
    // already decodes with the new bank.
    if (PROC_en && !nROMSEL) begin
      rom_bank_d = pDATA_IN[BANK_BITS-1:0];
    end

    unique case (tag1_q)
      TAG_VIDEO:  v_data_d     = MEM_RDATA;
      TAG_CPU:    p_data_out_d = MEM_RDATA;
      TAG_CPU_FF: p_data_out_d = 8'hFF;
      default:    ;
    endcase
  end

  // State update; reset drops any access in flight.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      p_data_out_q <= 8'h00;
      v_data_q     <= 8'h00;
      rom_bank_q   <= '0;
      mem_addr_q   <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= 8'h00;
      tag0_q       <= TAG_NONE;
      tag1_q       <= TAG_NONE;
    end else begin
      p_data_out_q <= p_data_out_d;
      v_data_q     <= v_data_d;
      rom_bank_q   <= rom_bank_d;
      mem_addr_q   <= mem_addr_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
      tag0_q       <= tag0_d;
      tag1_q       <= tag1_d;
    end
  end

  assign pDATA_OUT = p_data_out_q;
  assign vDATA     = v_data_q;
  assign ROM_BANK  = rom_bank_q;
  assign MEM_ADDR  = mem_addr_q;
  assign MEM_EN    = mem_en_q;
  assign MEM_WE    = mem_we_q;
  assign MEM_WDATA = mem_wdata_q;

endmodule

// File: tb/tb_sideways_mem_ctrl.sv
// tb_sideways_mem_ctrl
// Directed bench for sideways_mem_ctrl with a synchronous memory model.
// Banks 0,1,4,5 populated; bank 4 is sideways RAM.
module tb_sideways_mem_ctrl;

  // ---------------- clock / reset ----------------
  logic        CLK = 1'b0;
  logic        nRESET = 1'b0;
  logic        RAM_en = 1'b0;
  logic        PROC_en = 1'b0;
  logic [15:0] pADDR = 16'h0000;
  logic        RnW = 1'b1;
  logic [7:0]  pDATA_IN = 8'h00;
  logic        nROMSEL = 1'b1;
  logic [7:0]  pDATA_OUT;
  logic        pDATA_OE;
  logic [14:0] vADDR = 15'h0000;
  logic [7:0]  vDATA;
  logic [3:0]  ROM_BANK;
  logic [18:0] MEM_ADDR;
  logic        MEM_EN;
  logic        MEM_WE;
  logic [7:0]  MEM_WDATA;
  logic [7:0]  MEM_RDATA = 8'h00;

  always #5 CLK = ~CLK;

  sideways_mem_ctrl #(
    .BANK_BITS    (4),
    .BANK_PRESENT (16'h0033),
    .SWRAM_MASK   (16'h0010),
    .MEM_AW       (19)
  ) dut (
    .CLK       (CLK),
    .nRESET    (nRESET),
    .RAM_en    (RAM_en),
    .PROC_en   (PROC_en),
    .pADDR     (pADDR),
    .RnW       (RnW),
    .pDATA_IN  (pDATA_IN),
    .nROMSEL   (nROMSEL),
    .pDATA_OUT (pDATA_OUT),
    .pDATA_OE  (pDATA_OE),
    .vADDR     (vADDR),
    .vDATA     (vDATA),
    .ROM_BANK  (ROM_BANK),
    .MEM_ADDR  (MEM_ADDR),
    .MEM_EN    (MEM_EN),
    .MEM_WE    (MEM_WE),
    .MEM_WDATA (MEM_WDATA),
    .MEM_RDATA (MEM_RDATA)
  );

  // ---------------- memory model ----------------
  // Unwritten cells return a fixed address hash; read data is only valid
  // for the one cycle after the strobe, otherwise 8'hEE.
  logic [7:0] wmem [logic [18:0]];

  function automatic logic [7:0] pat(input logic [18:0] a);
    return a[7:0] ^ a[15:8] ^ {5'b0, a[18:16]} ^ 8'h5A;
  endfunction

  always @(posedge CLK) begin
    if (MEM_EN) begin
      if (MEM_WE) begin
        wmem[MEM_ADDR] = MEM_WDATA;
        MEM_RDATA <= 8'hEE;
      end else if (wmem.exists(MEM_ADDR)) begin
        MEM_RDATA <= wmem[MEM_ADDR];
      end else begin
        MEM_RDATA <= pat(MEM_ADDR);
      end
    end else begin
      MEM_RDATA <= 8'hEE;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        en;
    logic        we;
    logic [18:0] addr;
    logic [7:0]  wdata;
    logic        oe;
    logic [3:0]  bank;
    logic [7:0]  p;
    logic [7:0]  v;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  bit   mon_on = 1'b0;
  logic ram_en_s = 1'b0;

  logic [7:0] p_m = 8'h00;
  logic [7:0] v_m = 8'h00;
  logic [3:0] bank_m = 4'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge CLK) ram_en_s <= RAM_en;

  // Monitor: one record per RAM_en slot; strobe checked in t, data at t+2.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (mon_on && ram_en_s) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_slot: got slot with empty queue (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          chk("mem_en", 32'(MEM_EN), 32'(e.en));
          chk("mem_we", 32'(MEM_WE), 32'(e.we));
          if (e.en) chk("mem_addr", 32'(MEM_ADDR), 32'(e.addr));
          if (e.we) chk("mem_wdata", 32'(MEM_WDATA), 32'(e.wdata));
          chk("pdata_oe", 32'(pDATA_OE), 32'(e.oe));
          chk("rom_bank", 32'(ROM_BANK), 32'(e.bank));
          @(negedge CLK);
          chk("mem_en_pulse", 32'(MEM_EN), 32'd0);
          @(negedge CLK);
          chk("pdata_out", 32'(pDATA_OUT), 32'(e.p));
          chk("vdata", 32'(vDATA), 32'(e.v));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input bit vid, input bit rsel, input logic [15:0] a,
                       input logic rnw, input logic [7:0] d, input logic [14:0] va,
                       input logic x_en, input logic x_we, input logic [18:0] x_addr,
                       input logic x_oe, input logic [3:0] x_bank,
                       input logic [7:0] x_p, input logic [7:0] x_v);
    exp_t e;
    e = '{en: x_en, we: x_we, addr: x_addr, wdata: d, oe: x_oe,
          bank: x_bank, p: x_p, v: x_v};
    @(negedge CLK);
    exp_q.push_back(e);
    pADDR    = a;
    RnW      = rnw;
    pDATA_IN = d;
    vADDR    = va;
    RAM_en   = 1'b1;
    PROC_en  = vid;
    nROMSEL  = ~rsel;
    @(negedge CLK);
    RAM_en   = 1'b0;
    PROC_en  = 1'b0;
    nROMSEL  = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  task automatic vid_slot(input logic [14:0] va, input logic [18:0] x_addr, input logic [7:0] x_v);
    issue(1'b1, 1'b0, 16'h1234, 1'b1, 8'h00, va, 1'b1, 1'b0, x_addr, 1'b1, bank_m, p_m, x_v);
    v_m = x_v;
  endtask

  task automatic romsel(input logic [7:0] d, input logic [3:0] x_bank);
    issue(1'b1, 1'b1, 16'hFE30, 1'b0, d, 15'h3000, 1'b1, 1'b0, 19'h03000, 1'b0, x_bank, p_m, 8'h6A);
    bank_m = x_bank;
    v_m    = 8'h6A;
  endtask

  task automatic cpu_rd(input logic [15:0] a, input logic x_en, input logic [18:0] x_addr,
                        input logic x_oe, input logic [7:0] x_p);
    issue(1'b0, 1'b0, a, 1'b1, 8'h00, 15'h3000, x_en, 1'b0, x_addr, x_oe, bank_m, x_p, v_m);
    p_m = x_p;
  endtask

  task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d, input logic x_en,
                        input logic [18:0] x_addr);
    issue(1'b0, 1'b0, a, 1'b0, d, 15'h3000, x_en, x_en, x_addr, 1'b0, bank_m, p_m, v_m);
  endtask

  // ---------------- watchdog ----------------
  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin : main
    repeat (3) @(negedge CLK);
    chk("rst_pdata_out", 32'(pDATA_OUT), 32'h00);
    chk("rst_vdata",     32'(vDATA),     32'h00);
    chk("rst_rom_bank",  32'(ROM_BANK),  32'h0);
    chk("rst_mem_en",    32'(MEM_EN),    32'h0);
    chk("rst_mem_we",    32'(MEM_WE),    32'h0);
    chk("rst_mem_addr",  32'(MEM_ADDR),  32'h0);
    chk("rst_mem_wdata", 32'(MEM_WDATA), 32'h0);
    nRESET = 1'b1;
    repeat (2) @(negedge CLK);
    mon_on = 1'b1;

    // Interleave video and CPU slots every 4 CLK
    vid_slot(15'h3000, 19'h03000, 8'h6A);
    cpu_rd(16'h1234, 1'b1, 19'h01234, 1'b1, 8'h7C);
    vid_slot(15'h7FFF, 19'h07FFF, 8'hDA);
    cpu_rd(16'h4567, 1'b1, 19'h04567, 1'b1, 8'h78);
    vid_slot(15'h3000, 19'h03000, 8'h6A);
    cpu_rd(16'h1234, 1'b1, 19'h01234, 1'b1, 8'h7C);

    // ROMSEL then paged read
    romsel(8'hF5, 4'h5);
    cpu_rd(16'h8010, 1'b1, 19'h20010, 1'b1, 8'h48);

    // Sideways RAM bank 4: write, read back
    romsel(8'hE4, 4'h4);
    cpu_wr(16'h9000, 8'h55, 1'b1, 19'h1D000);
    cpu_rd(16'h9000, 1'b1, 19'h1D000, 1'b1, 8'h55);

    // Bank 0 is ROM: write dropped, cell unchanged
    romsel(8'h00, 4'h0);
    cpu_wr(16'h9000, 8'h66, 1'b0, 19'h0);
    cpu_rd(16'h9000, 1'b1, 19'h0D000, 1'b1, 8'h8A);

    // Unpopulated bank 7 reads as FF
    romsel(8'h07, 4'h7);
    cpu_rd(16'h8000, 1'b0, 19'h0, 1'b1, 8'hFF);

    // IO read: no access, data held, bus not driven
    cpu_rd(16'hFE40, 1'b0, 19'h0, 1'b0, 8'hFF);
    cpu_rd(16'hFC00, 1'b0, 19'h0, 1'b0, 8'hFF);

    // OS region and its edges
    cpu_rd(16'hFFFC, 1'b1, 19'h0BFFC, 1'b1, 8'h19);
    cpu_rd(16'hFF00, 1'b1, 19'h0BF00, 1'b1, 8'hE5);
    cpu_rd(16'hFBFF, 1'b1, 19'h0BBFF, 1'b1, 8'h1E);
    cpu_rd(16'hC123, 1'b1, 19'h08123, 1'b1, 8'hF8);
    cpu_wr(16'hC000, 8'h77, 1'b0, 19'h0);

    // Main RAM write then read back
    cpu_wr(16'h0100, 8'hA5, 1'b1, 19'h00100);
    cpu_rd(16'h0100, 1'b1, 19'h00100, 1'b1, 8'hA5);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge CLK);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: %0d records left expected 0", exp_q.size());
    end
    mon_on = 1'b0;

    // Reset in the middle of a CPU read slot
    @(negedge CLK);
    pADDR  = 16'h2222;
    RnW    = 1'b1;
    RAM_en = 1'b1;
    @(negedge CLK);
    RAM_en = 1'b0;
    chk("mid_rst_strobe", 32'(MEM_EN), 32'h1);
    #1 nRESET = 1'b0;
    #1;
    chk("mid_rst_pdata_out", 32'(pDATA_OUT), 32'h00);
    chk("mid_rst_vdata",     32'(vDATA),     32'h00);
    chk("mid_rst_rom_bank",  32'(ROM_BANK),  32'h0);
    chk("mid_rst_mem_en",    32'(MEM_EN),    32'h0);
    chk("mid_rst_mem_we",    32'(MEM_WE),    32'h0);
    chk("mid_rst_mem_addr",  32'(MEM_ADDR),  32'h0);
    chk("mid_rst_mem_wdata", 32'(MEM_WDATA), 32'h0);
    @(negedge CLK);
    nRESET = 1'b1;
    repeat (4) @(negedge CLK);
    chk("post_rst_pdata_out", 32'(pDATA_OUT), 32'h00);
    chk("post_rst_vdata",     32'(vDATA),     32'h00);
    chk("post_rst_mem_en",    32'(MEM_EN),    32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
